// File: rtl/vec_exec_pipe_if.sv
// vec_exec_pipe_if
//   Request/response bundle for the vector execute stage.
//   Request side : in_valid/in_ready handshake, vsew, vl, funct6, vec_src,
//                  v_operand_a (vs2), v_operand_b (vs1), v_old_vd, v_imm,
//                  v_scalar, and v_mask/vm when VEC_MASK_EN is defined.
//   Response side: out_valid/out_ready handshake, vec_exec_out, out_err.
//   master = producer of requests / consumer of results (pipeline side)
//   slave  = the execute stage itself
//   Optional macro: VEC_MASK_EN adds v_mask and vm.
interface vec_exec_pipe_if #(
  parameter int VLEN = 256,
  parameter int XLEN = 32,
  parameter int VL_W = $clog2(VLEN/8) + 1
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      vsew;
  logic [VL_W-1:0] vl;
  logic [5:0]      funct6;
  logic [1:0]      vec_src;
  logic [VLEN-1:0] v_operand_a;
  logic [VLEN-1:0] v_operand_b;
  logic [VLEN-1:0] v_old_vd;
  logic [4:0]      v_imm;
  logic [XLEN-1:0] v_scalar;
`ifdef VEC_MASK_EN
  logic [VLEN-1:0] v_mask;
  logic            vm;
`endif
  logic            out_valid;
  logic            out_ready;
  logic [VLEN-1:0] vec_exec_out;
  logic            out_err;

  modport master (
`ifdef VEC_MASK_EN
    output v_mask, vm,
`endif
    output in_valid, vsew, vl, funct6, vec_src, v_operand_a, v_operand_b,
    output v_old_vd, v_imm, v_scalar, out_ready,
    input  in_ready, out_valid, vec_exec_out, out_err
  );

  modport slave (
`ifdef VEC_MASK_EN
    input  v_mask, vm,
`endif
    input  in_valid, vsew, vl, funct6, vec_src, v_operand_a, v_operand_b,
    input  v_old_vd, v_imm, v_scalar, out_ready,
    output in_ready, out_valid, vec_exec_out, out_err
  );
endinterface

// File: rtl/vec_exec_pipe.sv
// vec_exec_pipe
//   Vector execute stage: applies one vector ALU operation NUM_PE elements
//   per beat, honouring a runtime vl with tail-undisturbed merge from the
//   old destination.
//   Ports:
//     clk   : clock
//     reset : synchronous, active-low reset
//     bus   : vec_exec_pipe_if.slave (request handshake + operands,
//             result handshake + vec_exec_out/out_err)
//   Optional macro: VEC_MASK_EN enables v0 masking (v_mask, vm; vm=1 means
//   unmasked). Masked-off active elements keep v_old_vd.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for a request
//   BUSY  | computing one beat per clock
//   DONE  | out_valid=1, result held until out_ready
module vec_exec_pipe #(
  parameter int VLEN   = 256,
  parameter int NUM_PE = 4,
  parameter int XLEN   = 32,
  parameter int VL_W   = $clog2(VLEN/8) + 1
) (
  input logic           clk,
  input logic           reset,
  vec_exec_pipe_if.slave bus
);

  localparam int PW     = $clog2(VLEN);
  localparam int LOG_PE = $clog2(NUM_PE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [VL_W-1:0] beat_q;
  logic [VL_W-1:0] beat_last_q;
  logic [VL_W-1:0] vle_q;
  logic [1:0]      sew_q;
  logic [5:0]      funct6_q;
  logic [1:0]      vec_src_q;
  logic [VLEN-1:0] va_q;
  logic [VLEN-1:0] vb_q;
  logic [4:0]      imm_q;
  logic [XLEN-1:0] scalar_q;
  logic [VLEN-1:0] out_q;
  logic            err_q;
`ifdef VEC_MASK_EN
  logic [VLEN-1:0] mask_q;
  logic            vm_q;
`endif

  // Effective vector length and beat count for the incoming request.
  logic [VL_W-1:0] vlmax_in;
  logic [VL_W-1:0] vle_in;
  logic [VL_W:0]   nb_in;

  assign vlmax_in = VL_W'(VLEN/8) >> bus.vsew[1:0];
  assign vle_in   = (bus.vl < vlmax_in) ? bus.vl : vlmax_in;
  assign nb_in    = ({1'b0, vle_in} + (VL_W+1)'(NUM_PE-1)) >> LOG_PE;

  function automatic logic [63:0] sew_mask(input logic [1:0] sew);
    case (sew)
      2'd0:    sew_mask = 64'h0000_0000_0000_00FF;
      2'd1:    sew_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    sew_mask = 64'h0000_0000_FFFF_FFFF;
      default: sew_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] sext(input logic [63:0] x, input logic [1:0] sew);
    case (sew)
      2'd0:    sext = {{56{x[7]}},  x[7:0]};
      2'd1:    sext = {{48{x[15]}}, x[15:0]};
      2'd2:    sext = {{32{x[31]}}, x[31:0]};
      default: sext = x;
    endcase
  endfunction

  // Computes element idx and merges it into cur if it is active.
  function automatic logic [VLEN-1:0] lane_update(input logic [VLEN-1:0] cur,
                                                  input logic [VL_W-1:0] idx);
    logic [PW-1:0] pos;
    logic [63:0]   m;
    logic [63:0]   a_raw;
    logic [63:0]   b_raw;
    logic [63:0]   a_u;
    logic [63:0]   b_u;
    logic [63:0]   a_s;
    logic [63:0]   b_s;
    logic [63:0]   r;
    logic          active;
    m     = sew_mask(sew_q);
    // Wraps only for idx >= VLMAX, which is never active.
    pos   = PW'(idx) << (3'(sew_q) + 3'd3);
    a_raw = 64'(va_q >> pos);
    case (vec_src_q)
      2'b01:   b_raw = 64'(scalar_q);
      2'b10:   b_raw = {{59{imm_q[4]}}, imm_q};
      default: b_raw = 64'(vb_q >> pos);
    endcase
    a_u = a_raw & m;
    b_u = b_raw & m;
    a_s = sext(a_u, sew_q);
    b_s = sext(b_u, sew_q);
    case (funct6_q)
      6'b000000: r = a_u + b_u;
      6'b000010: r = a_u - b_u;
      6'b000100: r = (a_u < b_u) ? a_u : b_u;
      6'b000101: r = ($signed(a_s) < $signed(b_s)) ? a_s : b_s;
      6'b000110: r = (a_u > b_u) ? a_u : b_u;
      6'b000111: r = ($signed(a_s) > $signed(b_s)) ? a_s : b_s;
      6'b001001: r = a_u & b_u;
      6'b001010: r = a_u | b_u;
      6'b001011: r = a_u ^ b_u;
      default:   r = 64'd0;
    endcase
    active = (idx < vle_q);
`ifdef VEC_MASK_EN
    active = active && (vm_q || mask_q[idx]);
`endif
    if (active)
      cur = (cur & ~(VLEN'(m) << pos)) | (VLEN'(r & m) << pos);
    lane_update = cur;
  endfunction

  logic [VL_W-1:0] beat_base;
  logic [VLEN-1:0] beat_out;

  assign beat_base = beat_q << LOG_PE;

  always_comb begin
    beat_out = out_q;
    for (int p = 0; p < NUM_PE; p++)
      beat_out = lane_update(beat_out, beat_base | VL_W'(p));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      beat_q <= '0;
      out_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            sew_q       <= bus.vsew[1:0];
            funct6_q    <= bus.funct6;
            vec_src_q   <= bus.vec_src;
            va_q        <= bus.v_operand_a;
            vb_q        <= bus.v_operand_b;
            imm_q       <= bus.v_imm;
            scalar_q    <= bus.v_scalar;
`ifdef VEC_MASK_EN
            mask_q      <= bus.v_mask;
            vm_q        <= bus.vm;
`endif
            vle_q       <= vle_in;
            beat_q      <= '0;
            beat_last_q <= VL_W'(nb_in - (VL_W+1)'(1));
            out_q       <= bus.v_old_vd;
            err_q       <= bus.vsew[2];
            if (bus.vsew[2] || (vle_in == '0))
              state <= S_DONE;
            else
              state <= S_BUSY;
          end
        end
        S_BUSY: begin
          out_q <= beat_out;
          if (beat_q == beat_last_q)
            state <= S_DONE;
          else
            beat_q <= beat_q + VL_W'(1);
        end
        S_DONE: begin
          if (bus.out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state == S_IDLE);
  assign bus.out_valid    = (state == S_DONE);
  assign bus.vec_exec_out = out_q;
  assign bus.out_err      = err_q;

endmodule
